phy_lane_checker: RTL and testbench

Synthesizable, parametrised lane-by-lane comparator for the PHY that checks the behavioural (cond) and structural (estruct) descriptions against each other on the word clock. It sits in the bench beside both PHY instances. It aligns the reference side through a programmable delay line and tracks per-lane sticky mismatch flags, saturating counters and a first-error capture. It replaces the fixed two-lane, print-only comparison with a reusable block that the bench can read back as registers.

---
 rtl/phy_lane_checker.sv | 273 +++++++++++++++++++++++++++
 tb/tb_phy_lane_checker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_lane_checker.sv
// ---------------------------------------------------------------------------
// phy_lane_checker
//
// Lane-by-lane comparator between a reference PHY stream (cond) and a DUT PHY
// stream (estruct). The reference side is delayed by a programmable number of
// word-clock cycles before it is compared. Per-lane sticky mismatch flags,
// saturating error and word counters, and a first-error capture are kept as
// registers the bench can read back.
//
// Optional feature macro: PHY_CHK_IDLE_CHECK_EN
//   When defined, a lane whose two valids are both low is still flagged if the
//   DUT data is not IDLE_SYM. When undefined, invalid data is ignored.
//
// Ports:
//   clk_f          word clock, all state updates on its rising edge
//   reset_L        asynchronous active-low reset
//   enable         checker run enable (low forces IDLE, counts are held)
//   clear          synchronous clear of flags, counters and capture
//   align_dly      reference delay in cycles (clamped to ALIGN_DEPTH)
//   data_ref       reference data, lane i at [i*WIDTH +: WIDTH]
//   valid_ref      reference valids
//   data_dut       DUT data
//   valid_dut      DUT valids
//   mismatch       sticky per-lane mismatch flags
//   err_count      mismatching compare cycles, saturating
//   word_count     compare cycles with any valid lane, saturating
//   first_err_lane lowest mismatching lane of the first error cycle
//   first_err_ref  aligned reference data at the first error
//   first_err_dut  DUT data at the first error
//   state          0 IDLE, 1 SYNC, 2 CHECK, 3 FAIL
// ---------------------------------------------------------------------------
module phy_lane_checker #(
    parameter int                LANES       = 2,
    parameter int                WIDTH       = 8,
    parameter int                ALIGN_DEPTH = 4,
    parameter int                CNT_W       = 16,
    parameter logic [WIDTH-1:0]  IDLE_SYM    = 8'hBC,
    localparam int               AW          = $clog2(ALIGN_DEPTH + 1),
    localparam int               LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk_f,
    input  logic                     reset_L,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [AW-1:0]            align_dly,
    input  logic [LANES*WIDTH-1:0]   data_ref,
    input  logic [LANES-1:0]         valid_ref,
    input  logic [LANES*WIDTH-1:0]   data_dut,
    input  logic [LANES-1:0]         valid_dut,
    output logic [LANES-1:0]         mismatch,
    output logic [CNT_W-1:0]         err_count,
    output logic [CNT_W-1:0]         word_count,
    output logic [LW-1:0]            first_err_lane,
    output logic [WIDTH-1:0]         first_err_ref,
    output logic [WIDTH-1:0]         first_err_dut,
    output logic [1:0]               state
);

    localparam int DW = LANES * (WIDTH + 1);

`ifdef PHY_CHK_IDLE_CHECK_EN
    localparam bit IDLE_CHECK = 1'b1;
`else
    localparam bit IDLE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Reference delay line: stage k holds the input from k+1 cycles ago.
    // It shifts every cycle regardless of FSM state or clear.
    // ------------------------------------------------------------------
    logic [DW-1:0] line_in;
    logic [DW-1:0] dl_q [ALIGN_DEPTH];
    logic [DW-1:0] dl_d [ALIGN_DEPTH];

    assign line_in = {valid_ref, data_ref};

    always_comb begin
        dl_d[0] = line_in;
        for (int k = 1; k < ALIGN_DEPTH; k++) begin
            dl_d[k] = dl_q[k-1];
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < ALIGN_DEPTH; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < ALIGN_DEPTH; k++) begin
                dl_q[k] <= dl_d[k];
            end
        end
    end

    // Tap select; a delay of 0 bypasses the line combinationally.
    logic [AW-1:0]          dly_sel;
    logic [DW-1:0]          aligned;
    logic [LANES-1:0]       aligned_valid;
    logic [LANES*WIDTH-1:0] aligned_data;

    always_comb begin
        dly_sel = (int'(align_dly) > ALIGN_DEPTH) ? AW'(ALIGN_DEPTH) : align_dly;
        aligned = line_in;
        for (int k = 1; k <= ALIGN_DEPTH; k++) begin
            if (int'(dly_sel) == k) begin
                aligned = dl_q[k-1];
            end
        end
    end

    assign aligned_valid = aligned[DW-1 -: LANES];
    assign aligned_data  = aligned[LANES*WIDTH-1:0];

    // ------------------------------------------------------------------
    // Per-lane compare
    // ------------------------------------------------------------------
    logic [LANES-1:0] lane_err;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] ref_w;
            logic [WIDTH-1:0] dut_w;
            logic             vr;
            logic             vd;

            assign ref_w = aligned_data[gi*WIDTH +: WIDTH];
            assign dut_w = data_dut[gi*WIDTH +: WIDTH];
            assign vr    = aligned_valid[gi];
            assign vd    = valid_dut[gi];

            assign lane_err[gi] = (vr != vd)
                                | (vr & vd & (ref_w != dut_w))
                                | (IDLE_CHECK & ~vr & ~vd & (dut_w != IDLE_SYM));
        end
    endgenerate

    // Lowest mismatching lane wins the capture: scan high to low so the
    // last assignment is the lowest index.
    logic [LW-1:0]    sel_lane;
    logic [WIDTH-1:0] sel_ref;
    logic [WIDTH-1:0] sel_dut;

    always_comb begin
        sel_lane = '0;
        sel_ref  = '0;
        sel_dut  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_err[i]) begin
                sel_lane = LW'(i);
                sel_ref  = aligned_data[i*WIDTH +: WIDTH];
                sel_dut  = data_dut[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM, flags, counters and capture
    // ------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [LANES-1:0] mismatch_q,   mismatch_d;
    logic [CNT_W-1:0] err_count_q,  err_count_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [LW-1:0]    cap_lane_q,   cap_lane_d;
    logic [WIDTH-1:0] cap_ref_q,    cap_ref_d;
    logic [WIDTH-1:0] cap_dut_q,    cap_dut_d;
    logic             cap_done_q,   cap_done_d;
    logic             active;
    logic             any_err;
    logic             any_valid;

    assign any_err   = |lane_err;
    assign any_valid = (|aligned_valid) | (|valid_dut);

    always_comb begin
        state_d      = state_q;
        mismatch_d   = mismatch_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        cap_lane_d   = cap_lane_q;
        cap_ref_d    = cap_ref_q;
        cap_dut_d    = cap_dut_q;
        cap_done_d   = cap_done_q;
        active       = 1'b0;

        if (clear) begin
            // Clear takes priority over anything observed this cycle.
            mismatch_d   = '0;
            err_count_d  = '0;
            word_count_d = '0;
            cap_lane_d   = '0;
            cap_ref_d    = '0;
            cap_dut_d    = '0;
            cap_done_d   = 1'b0;
            state_d      = enable ? ST_SYNC : ST_IDLE;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    // The cycle that first shows an aligned valid is compared.
                    if (|aligned_valid) begin
                        active  = 1'b1;
                        state_d = any_err ? ST_FAIL : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    active = 1'b1;
                    if (any_err) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_FAIL: active = 1'b1;
                default: state_d = ST_IDLE;
            endcase

            if (active) begin
                mismatch_d = mismatch_q | lane_err;
                if (any_err && (err_count_q != '1)) begin
                    err_count_d = err_count_q + 1'b1;
                end
                if (any_valid && (word_count_q != '1)) begin
                    word_count_d = word_count_q + 1'b1;
                end
                if (any_err && !cap_done_q) begin
                    cap_lane_d = sel_lane;
                    cap_ref_d  = sel_ref;
                    cap_dut_d  = sel_dut;
                    cap_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            mismatch_q   <= '0;
            err_count_q  <= '0;
            word_count_q <= '0;
            cap_lane_q   <= '0;
            cap_ref_q    <= '0;
            cap_dut_q    <= '0;
            cap_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mismatch_q   <= mismatch_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            cap_lane_q   <= cap_lane_d;
            cap_ref_q    <= cap_ref_d;
            cap_dut_q    <= cap_dut_d;
            cap_done_q   <= cap_done_d;
        end
    end

    assign state          = state_q;
    assign mismatch       = mismatch_q;
    assign err_count      = err_count_q;
    assign word_count     = word_count_q;
    assign first_err_lane = cap_lane_q;
    assign first_err_ref  = cap_ref_q;
    assign first_err_dut  = cap_dut_q;

endmodule

// File: tb/tb_phy_lane_checker.sv
// ---------------------------------------------------------------------------
// tb_phy_lane_checker
//
// Drives two checker instances (16-bit and 4-bit counters) with the same
// stimulus: directed scenarios followed by randomized traffic. A behavioural
// model built from the comparison rules (history queue for the reference
// delay, integer counters clipped at the counter maximum) predicts every
// output after every clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_phy_lane_checker;

    localparam int LANES       = 2;
    localparam int WIDTH       = 8;
    localparam int ALIGN_DEPTH = 4;
    localparam int AW          = $clog2(ALIGN_DEPTH + 1);
    localparam int LW          = 1;
    localparam int DW          = LANES * (WIDTH + 1);
    localparam logic [WIDTH-1:0] IDLE = 8'hBC;
`ifdef PHY_CHK_IDLE_CHECK_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    logic                   clk_f = 1'b0;
    logic                   reset_L;
    logic                   enable;
    logic                   clear;
    logic [AW-1:0]          align_dly;
    logic [LANES*WIDTH-1:0] data_ref;
    logic [LANES-1:0]       valid_ref;
    logic [LANES*WIDTH-1:0] data_dut;
    logic [LANES-1:0]       valid_dut;

    logic [LANES-1:0] mismatch,   s_mismatch;
    logic [15:0]      err_count,  word_count;
    logic [3:0]       s_err_count, s_word_count;
    logic [LW-1:0]    first_err_lane, s_first_err_lane;
    logic [WIDTH-1:0] first_err_ref,  s_first_err_ref;
    logic [WIDTH-1:0] first_err_dut,  s_first_err_dut;
    logic [1:0]       state, s_state;

    always #5 clk_f = ~clk_f;

    phy_lane_checker #(.LANES(LANES), .WIDTH(WIDTH), .ALIGN_DEPTH(ALIGN_DEPTH), .CNT_W(16)) dut (
        .clk_f(clk_f), .reset_L(reset_L), .enable(enable), .clear(clear),
        .align_dly(align_dly), .data_ref(data_ref), .valid_ref(valid_ref),
        .data_dut(data_dut), .valid_dut(valid_dut), .mismatch(mismatch),
        .err_count(err_count), .word_count(word_count),
        .first_err_lane(first_err_lane), .first_err_ref(first_err_ref),
        .first_err_dut(first_err_dut), .state(state)
    );

    phy_lane_checker #(.LANES(LANES), .WIDTH(WIDTH), .ALIGN_DEPTH(ALIGN_DEPTH), .CNT_W(4)) dut_s (
        .clk_f(clk_f), .reset_L(reset_L), .enable(enable), .clear(clear),
        .align_dly(align_dly), .data_ref(data_ref), .valid_ref(valid_ref),
        .data_dut(data_dut), .valid_dut(valid_dut), .mismatch(s_mismatch),
        .err_count(s_err_count), .word_count(s_word_count),
        .first_err_lane(s_first_err_lane), .first_err_ref(s_first_err_ref),
        .first_err_dut(s_first_err_dut), .state(s_state)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]    hist[$];      // hist[0] = input one cycle ago
    int               m_state;      // 0 IDLE 1 SYNC 2 CHECK 3 FAIL
    logic [LANES-1:0] m_mis;
    int               m_err, m_word;
    bit               m_cap_done;
    int               m_lane;
    logic [WIDTH-1:0] m_cref, m_cdut;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < ALIGN_DEPTH; k++) hist.push_back('0);
        m_state = 0; m_mis = '0; m_err = 0; m_word = 0;
        m_cap_done = 0; m_lane = 0; m_cref = '0; m_cdut = '0;
    endtask

    function automatic logic [DW-1:0] model_aligned(input logic [DW-1:0] cur);
        int d;
        d = (int'(align_dly) > ALIGN_DEPTH) ? ALIGN_DEPTH : int'(align_dly);
        return (d == 0) ? cur : hist[d-1];
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        logic [DW-1:0]          cur, al;
        logic [LANES-1:0]       avr;
        logic [LANES*WIDTH-1:0] adr;
        logic [LANES-1:0]       e;
        logic [WIDTH-1:0]       r, d;
        bit                     act;
        cur = {valid_ref, data_ref};
        al  = model_aligned(cur);
        avr = al[DW-1 -: LANES];
        adr = al[LANES*WIDTH-1:0];
        for (int i = 0; i < LANES; i++) begin
            r = adr[i*WIDTH +: WIDTH];
            d = data_dut[i*WIDTH +: WIDTH];
            if (avr[i] != valid_dut[i])      e[i] = 1'b1;
            else if (avr[i])                 e[i] = (r != d);
            else                             e[i] = IDLE_EN && (d != IDLE);
        end
        act = 0;
        if (clear) begin
            m_mis = '0; m_err = 0; m_word = 0; m_cap_done = 0;
            m_lane = 0; m_cref = '0; m_cdut = '0;
            m_state = enable ? 1 : 0;
        end else if (!enable) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (avr != 0) begin
                act = 1;
                m_state = (e != 0) ? 3 : 2;
            end
        end else begin
            act = 1;
            if (e != 0) m_state = 3;
        end
        if (act) begin
            m_mis |= e;
            if (e != 0) m_err++;
            if ((avr != 0) || (valid_dut != 0)) m_word++;
            if ((e != 0) && !m_cap_done) begin
                m_cap_done = 1;
                for (int i = 0; i < LANES; i++) begin
                    if (e[i]) begin
                        m_lane = i;
                        m_cref = adr[i*WIDTH +: WIDTH];
                        m_cdut = data_dut[i*WIDTH +: WIDTH];
                        break;
                    end
                end
            end
        end
        hist.push_front(cur);
        void'(hist.pop_back());
    endtask

    task automatic check_all();
        check_val("mismatch",  64'(mismatch),       64'(m_mis));
        check_val("err_count", 64'(err_count),      64'(sat(m_err, 16)));
        check_val("word_count",64'(word_count),     64'(sat(m_word, 16)));
        check_val("err_lane",  64'(first_err_lane), 64'(m_lane));
        check_val("err_ref",   64'(first_err_ref),  64'(m_cref));
        check_val("err_dut",   64'(first_err_dut),  64'(m_cdut));
        check_val("state",     64'(state),          64'(m_state));
        check_val("s_mismatch",64'(s_mismatch),     64'(m_mis));
        check_val("s_err_cnt", 64'(s_err_count),    64'(sat(m_err, 4)));
        check_val("s_word_cnt",64'(s_word_count),   64'(sat(m_word, 4)));
        check_val("s_err_lane",64'(s_first_err_lane),64'(m_lane));
        check_val("s_err_ref", 64'(s_first_err_ref), 64'(m_cref));
        check_val("s_err_dut", 64'(s_first_err_dut), 64'(m_cdut));
        check_val("s_state",   64'(s_state),        64'(m_state));
    endtask

    // One clock: model predicts, edge, sample 1ns later.
    task automatic step();
        model_step();
        @(posedge clk_f);
        #1;
        check_all();
        txn++;
        $display("txn %0d en=%0b clr=%0b dly=%0d vr=%b vd=%b st=%0d mis=%b err=%0d words=%0d",
                 txn, enable, clear, align_dly, valid_ref, valid_dut, state, mismatch,
                 err_count, word_count);
    endtask

    task automatic drive_idle();
        valid_ref = '0; valid_dut = '0;
        data_ref  = {IDLE, IDLE}; data_dut = {IDLE, IDLE};
    endtask

    task automatic drive_word(input logic [15:0] r, input logic [15:0] d,
                              input logic [1:0] vr, input logic [1:0] vd);
        data_ref = r; data_dut = d; valid_ref = vr; valid_dut = vd;
    endtask

    logic [15:0] stream[8];
    logic [7:0]  alpha[4];

    initial begin
        alpha[0] = 8'hBC; alpha[1] = 8'h0C; alpha[2] = 8'h0D; alpha[3] = 8'hAC;
        reset_L = 1'b0; enable = 1'b0; clear = 1'b0; align_dly = '0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk_f);
        #1;
        check_all();
        reset_L = 1'b1;

        // Identical streams, align 0.
        enable = 1'b1;
        step();
        drive_word({8'hCC, 8'hDD}, {8'hCC, 8'hDD}, 2'b11, 2'b11); step();
        drive_word({8'hBC, 8'hEC}, {8'hBC, 8'hEC}, 2'b11, 2'b11); step();
        drive_word({8'h0C, 8'hAC}, {8'h0C, 8'hAC}, 2'b11, 2'b11); step();
        check_val("t1_state", 64'(state), 64'd2);
        check_val("t1_words", 64'(word_count), 64'd3);
        check_val("t1_errs",  64'(err_count), 64'd0);

        // Lane 1 corrupted.
        drive_word({8'h0C, 8'hAC}, {8'h0D, 8'hAC}, 2'b11, 2'b11); step();
        check_val("t2_mis",   64'(mismatch), 64'b10);
        check_val("t2_errs",  64'(err_count), 64'd1);
        check_val("t2_state", 64'(state), 64'd3);
        check_val("t2_lane",  64'(first_err_lane), 64'd1);
        check_val("t2_ref",   64'(first_err_ref), 64'h0C);
        check_val("t2_dut",   64'(first_err_dut), 64'h0D);

        // DUT lags reference by two cycles: align 2 clean, align 1 errors.
        for (int k = 0; k < 8; k++) stream[k] = 16'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            align_dly = (pass == 0) ? AW'(2) : AW'(1);
            drive_idle();
            repeat (3) step();
            clear = 1'b1; step(); clear = 1'b0;
            for (int t = 0; t < 10; t++) begin
                data_ref  = (t < 8) ? stream[t] : {IDLE, IDLE};
                valid_ref = (t < 8) ? 2'b11 : 2'b00;
                data_dut  = (t >= 2) ? stream[t-2] : {IDLE, IDLE};
                valid_dut = (t >= 2) ? 2'b11 : 2'b00;
                step();
            end
            if (pass == 0) begin
                check_val("t3_errs",  64'(err_count), 64'd0);
                check_val("t3_words", 64'(word_count), 64'd8);
                check_val("t3_state", 64'(state), 64'd2);
            end else begin
                check_val("t3_errs_seen", 64'(err_count != 0), 64'd1);
                check_val("t3_fail",      64'(state), 64'd3);
            end
        end

        // Saturation and clear beating a mismatch.
        align_dly = '0;
        drive_idle();
        clear = 1'b1; step(); clear = 1'b0;
        drive_word({8'h11, 8'h22}, {8'h11, 8'h22}, 2'b11, 2'b00);
        repeat (20) step();
        check_val("t4_sat",  64'(s_err_count), 64'hF);
        check_val("t4_wide", 64'(err_count), 64'd20);
        clear = 1'b1; step(); clear = 1'b0;
        check_val("t4_clr_err",  64'(s_err_count), 64'd0);
        check_val("t4_clr_mis",  64'(mismatch), 64'd0);
        check_val("t4_clr_st",   64'(state), 64'd1);

        // Idle-symbol check.
        drive_idle();
        clear = 1'b1; step(); clear = 1'b0;
        drive_word({8'h01, 8'h02}, {8'h01, 8'h02}, 2'b11, 2'b11); step();
        drive_word({IDLE, IDLE}, {8'h77, 8'h77}, 2'b00, 2'b00); step();
        check_val("t5_idle77", 64'(mismatch), IDLE_EN ? 64'b11 : 64'b00);
        drive_idle();
        clear = 1'b1; step(); clear = 1'b0;
        drive_word({8'h01, 8'h02}, {8'h01, 8'h02}, 2'b11, 2'b11); step();
        drive_idle(); step();
        check_val("t5_idleBC", 64'(mismatch), 64'b00);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [DW-1:0] al;
            clear  = 1'b0;
            enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) begin
                align_dly = AW'($urandom_range(0, 7));
                clear = 1'b1;
            end
            if ($urandom_range(0, 24) == 0) clear = 1'b1;
            valid_ref = LANES'($urandom);
            for (int i = 0; i < LANES; i++)
                data_ref[i*WIDTH +: WIDTH] = alpha[$urandom_range(0, 3)];
            al = model_aligned({valid_ref, data_ref});
            if ($urandom_range(0, 9) != 0) begin
                valid_dut = al[DW-1 -: LANES];
                for (int i = 0; i < LANES; i++)
                    data_dut[i*WIDTH +: WIDTH] = valid_dut[i] ? al[i*WIDTH +: WIDTH] : IDLE;
            end else begin
                valid_dut = LANES'($urandom);
                for (int i = 0; i < LANES; i++)
                    data_dut[i*WIDTH +: WIDTH] = alpha[$urandom_range(0, 3)];
            end
            step();
        end

        // Asynchronous reset while in FAIL.
        enable = 1'b1; clear = 1'b1; align_dly = '0; drive_idle(); step();
        clear = 1'b0;
        drive_word({8'h01, 8'h02}, {8'h01, 8'h03}, 2'b11, 2'b11); step();
        check_val("t6_pre_fail", 64'(state), 64'd3);
        #3;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("t6_rst_state", 64'(state), 64'd0);
        #2;
        reset_L = 1'b1;
        drive_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
